// File: rtl/mem_arbiter.sv
// Shares one single-port unified SRAM between instruction fetch and the MEM-stage data port.
// Fixed-latency access, DM-first priority with an anti-starvation limit for pending fetches.
module mem_arbiter #(
  parameter int unsigned LATENCY       = 1,
  parameter logic [11:0] IM_BASE       = 12'hC00,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        im_req,
  input  logic [9:0]  im_address,
  output logic [31:0] im_rdata,
  output logic        im_done,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [11:0] dm_address,
  input  logic [31:0] dm_in,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        stall,
  output logic        mem_enable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_address,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  localparam logic [2:0] LatCount  = 3'(LATENCY);
  localparam logic [3:0] StreakMax = 4'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        grantDm_q, grantDm_d;
  logic        isWrite_q, isWrite_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] imRdata_q, imRdata_d;
  logic [31:0] dmRdata_q, dmRdata_d;
  logic        memEnable_q, memEnable_d;
  logic        memRead_q, memRead_d;
  logic        memWrite_q, memWrite_d;
  logic [11:0] memAddress_q, memAddress_d;
  logic [31:0] memIn_q, memIn_d;
  logic        imDone_q, imDone_d;
  logic        dmDone_q, dmDone_d;

  logic        dmReq;
  logic        anyReq;
  logic        grantIm;
  logic        nextWrite;
  logic [11:0] imAddr;

  // Fetch only beats a pending data request once DM has used up its streak allowance.
  assign dmReq     = dm_read | dm_write;
  assign anyReq    = im_req | dmReq;
  assign grantIm   = im_req & (~dmReq | (streak_q == StreakMax));
  assign nextWrite = ~grantIm & dm_write;
  assign imAddr    = IM_BASE + {2'b00, im_address};

  assign stall = (im_req & ~imDone_q) | (dmReq & ~dmDone_q);

  assign im_rdata    = imRdata_q;
  assign dm_rdata    = dmRdata_q;
  assign im_done     = imDone_q;
  assign dm_done     = dmDone_q;
  assign mem_enable  = memEnable_q;
  assign mem_read    = memRead_q;
  assign mem_write   = memWrite_q;
  assign mem_address = memAddress_q;
  assign mem_in      = memIn_q;

  always_comb begin
    state_d      = state_q;
    grantDm_d    = grantDm_q;
    isWrite_d    = isWrite_q;
    count_d      = count_q;
    streak_d     = streak_q;
    imRdata_d    = imRdata_q;
    dmRdata_d    = dmRdata_q;
    memEnable_d  = 1'b0;
    memRead_d    = 1'b0;
    memWrite_d   = 1'b0;
    memAddress_d = 12'h000;
    memIn_d      = 32'h0000_0000;
    imDone_d     = 1'b0;
    dmDone_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!im_req) begin
          streak_d = 4'd0;
        end
        if (anyReq) begin
          // The memory command is registered here so it appears for exactly the ISSUE cycle.
          grantDm_d    = ~grantIm;
          isWrite_d    = nextWrite;
          memEnable_d  = 1'b1;
          memRead_d    = ~nextWrite;
          memWrite_d   = nextWrite;
          memAddress_d = grantIm ? imAddr : dm_address;
          memIn_d      = nextWrite ? dm_in : 32'h0000_0000;
          if (grantIm) begin
            streak_d = 4'd0;
          end else if (im_req && (streak_q < StreakMax)) begin
            streak_d = streak_q + 4'd1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        count_d = 3'd1;
        state_d = WAIT;
      end

      WAIT: begin
        if (count_q == LatCount) begin
          if (!isWrite_q) begin
            if (grantDm_q) begin
              dmRdata_d = mem_out;
            end else begin
              imRdata_d = mem_out;
            end
          end
          dmDone_d = grantDm_q;
          imDone_d = ~grantDm_q;
          state_d  = DONE;
        end else begin
          count_d = count_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grantDm_q    <= 1'b0;
      isWrite_q    <= 1'b0;
      count_q      <= 3'd0;
      streak_q     <= 4'd0;
      imRdata_q    <= 32'h0000_0000;
      dmRdata_q    <= 32'h0000_0000;
      memEnable_q  <= 1'b0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      memAddress_q <= 12'h000;
      memIn_q      <= 32'h0000_0000;
      imDone_q     <= 1'b0;
      dmDone_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grantDm_q    <= grantDm_d;
      isWrite_q    <= isWrite_d;
      count_q      <= count_d;
      streak_q     <= streak_d;
      imRdata_q    <= imRdata_d;
      dmRdata_q    <= dmRdata_d;
      memEnable_q  <= memEnable_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      memAddress_q <= memAddress_d;
      memIn_q      <= memIn_d;
      imDone_q     <= imDone_d;
      dmDone_q     <= dmDone_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM model with matching latency plus an ordered
// scoreboard of expected memory commands and completions.
module tb_mem_arbiter;

  localparam int          LAT  = 3;
  localparam logic [11:0] IMB  = 12'hF00;
  localparam int          MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req = 1'b0;
  logic [9:0]  im_address = 10'h000;
  logic [31:0] im_rdata;
  logic        im_done;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [11:0] dm_address = 12'h000;
  logic [31:0] dm_in = 32'h0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        stall;
  logic        mem_enable;
  logic        mem_read;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [31:0] mem_in;
  logic [31:0] mem_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cmdCyc = 0;
  int nCmdRd = 0;
  int nCmdWr = 0;
  int nImDone = 0;
  int nDmDone = 0;

  typedef struct {
    logic        dm;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xact_t;

  xact_t       expQ[$];
  logic [31:0] shadow [logic [11:0]];

  always #5 clk = ~clk;

  mem_arbiter #(
    .LATENCY      (LAT),
    .IM_BASE      (IMB),
    .MAX_DM_STREAK(MAXS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .im_req     (im_req),
    .im_address (im_address),
    .im_rdata   (im_rdata),
    .im_done    (im_done),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_address (dm_address),
    .dm_in      (dm_in),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .stall      (stall),
    .mem_enable (mem_enable),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_out    (mem_out)
  );

  function automatic logic [31:0] pattern(input logic [11:0] a);
    return {4'hD, a, 4'hB, a ^ 12'h5A5};
  endfunction

  // Unwritten words read back as a fixed address pattern.
  logic [31:0] sram [4096];
  bit          sramValid [4096];
  logic [31:0] rdPipe [LAT];

  always @(posedge clk) begin
    if (mem_enable && mem_write) begin
      sram[mem_address]      <= mem_in;
      sramValid[mem_address] <= 1'b1;
    end
    rdPipe[0] <= (mem_enable && mem_read) ?
                 (sramValid[mem_address] ? sram[mem_address] : pattern(mem_address)) : 32'h0;
    for (int k = 1; k < LAT; k++) begin
      rdPipe[k] <= rdPipe[k-1];
    end
  end

  assign mem_out = rdPipe[LAT-1];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: every command and every done pulse is matched against the head of expQ.
  initial begin
    xact_t x;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (mem_enable === 1'b1) begin
        checks++;
        cmdCyc = cyc;
        if (mem_read === 1'b1) nCmdRd++;
        if (mem_write === 1'b1) nCmdWr++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_cmd_unexpected: got addr=%h rd=%b wr=%b, required no command",
                   mem_address, mem_read, mem_write);
        end else if (mem_address !== expQ[0].addr || mem_read !== ~expQ[0].wr ||
                     mem_write !== expQ[0].wr || (expQ[0].wr && mem_in !== expQ[0].wdata)) begin
          errors++;
          $display("[TB] FAIL sb_cmd: got addr=%h rd=%b wr=%b din=%h, required addr=%h rd=%b wr=%b din=%h",
                   mem_address, mem_read, mem_write, mem_in,
                   expQ[0].addr, ~expQ[0].wr, expQ[0].wr, expQ[0].wdata);
        end
      end
      if (im_done === 1'b1 || dm_done === 1'b1) begin
        checks++;
        if (im_done === 1'b1) nImDone++;
        if (dm_done === 1'b1) nDmDone++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_done_unexpected: got im_done=%b dm_done=%b, required none",
                   im_done, dm_done);
        end else begin
          x = expQ.pop_front();
          if (im_done !== ~x.dm || dm_done !== x.dm) begin
            errors++;
            $display("[TB] FAIL sb_done_port: got im_done=%b dm_done=%b, required im_done=%b dm_done=%b",
                     im_done, dm_done, ~x.dm, x.dm);
          end else if (!x.wr && (x.dm ? dm_rdata : im_rdata) !== x.rdata) begin
            errors++;
            $display("[TB] FAIL sb_rdata: addr=%h got %h, required %h",
                     x.addr, x.dm ? dm_rdata : im_rdata, x.rdata);
          end else if (cyc - cmdCyc != LAT + 1) begin
            errors++;
            $display("[TB] FAIL sb_done_latency: got %0d cycles after command, required %0d",
                     cyc - cmdCyc, LAT + 1);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic dm, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata);
    xact_t x;
    x.dm    = dm;
    x.wr    = wr;
    x.addr  = addr;
    x.wdata = wdata;
    x.rdata = shadow.exists(addr) ? shadow[addr] : pattern(addr);
    if (wr) shadow[addr] = wdata;
    expQ.push_back(x);
  endtask

  // Waits for a done pulse; at = -1 on timeout. stallHi counts sampled cycles with stall high.
  task automatic waitDone(input bit dm, input int limit, output int at, output int stallHi);
    at = -1;
    stallHi = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (stall === 1'b1) stallHi++;
      if ((dm ? dm_done : im_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({mem_enable, mem_read, mem_write, mem_address, mem_in, im_done, dm_done,
         im_rdata, dm_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got en=%b rd=%b wr=%b addr=%h din=%h imd=%b dmd=%b imr=%h dmr=%h, required all 0",
               mem_enable, mem_read, mem_write, mem_address, mem_in, im_done, dm_done,
               im_rdata, dm_rdata);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stall_idle: got %b, required 0", stall);
    end
    im_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_stall_comb: got %b, required 1", stall);
    end
    im_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    int r, at, sh;
    pushExp(1'b0, 1'b0, 12'hF05, 32'h0);
    im_address = 10'h005;
    im_req     = 1'b1;
    r = cyc;
    waitDone(1'b0, 20, at, sh);
    checks++;
    if (at != r + LAT + 2) begin
      errors++;
      $display("[TB] FAIL if_read_latency: got cycle %0d, required %0d", at, r + LAT + 2);
    end
    checks++;
    if (sh != LAT + 2) begin
      errors++;
      $display("[TB] FAIL if_read_stall: got %0d stall cycles, required %0d", sh, LAT + 2);
    end
    checks++;
    if (im_rdata !== pattern(12'hF05)) begin
      errors++;
      $display("[TB] FAIL if_read_data: got %h, required %h", im_rdata, pattern(12'hF05));
    end
    tick();
    im_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int r, dmAt, imAt, stallLo;
    bit d;
    pushExp(1'b1, 1'b0, 12'h010, 32'h0);
    pushExp(1'b0, 1'b0, 12'hF0A, 32'h0);
    im_address = 10'h00A;
    im_req     = 1'b1;
    dm_address = 12'h010;
    dm_read    = 1'b1;
    r = cyc;
    dmAt = -1;
    imAt = -1;
    stallLo = 0;
    for (int i = 0; i < 40 && imAt < 0; i++) begin
      @(negedge clk);
      d = dm_done;
      if (d) dmAt = cyc;
      if (im_done === 1'b1) imAt = cyc;
      else if (stall !== 1'b1) stallLo++;
      if (d) begin
        tick();
        dm_read = 1'b0;
      end
    end
    checks++;
    if (dmAt != r + LAT + 2) begin
      errors++;
      $display("[TB] FAIL arb_dm_first: got dm_done at %0d, required %0d", dmAt, r + LAT + 2);
    end
    checks++;
    if (imAt != r + 2 * LAT + 5) begin
      errors++;
      $display("[TB] FAIL arb_if_next: got im_done at %0d, required %0d", imAt, r + 2 * LAT + 5);
    end
    checks++;
    if (stallLo != 0) begin
      errors++;
      $display("[TB] FAIL arb_stall: got %0d low cycles, required 0", stallLo);
    end
    tick();
    im_req = 1'b0;
    dm_read = 1'b0;
    tick();
  endtask

  task automatic test_write_both();
    int r, at, sh, rd0, wr0, dd0;
    rd0 = nCmdRd;
    wr0 = nCmdWr;
    dd0 = nDmDone;
    pushExp(1'b1, 1'b1, 12'h020, 32'h1234_5678);
    dm_address = 12'h020;
    dm_in      = 32'h1234_5678;
    dm_read    = 1'b1;
    dm_write   = 1'b1;
    r = cyc;
    waitDone(1'b1, 20, at, sh);
    checks++;
    if (at != r + LAT + 2) begin
      errors++;
      $display("[TB] FAIL write_latency: got cycle %0d, required %0d", at, r + LAT + 2);
    end
    checks++;
    if (dm_rdata !== pattern(12'h010)) begin
      errors++;
      $display("[TB] FAIL write_keeps_rdata: got %h, required %h", dm_rdata, pattern(12'h010));
    end
    tick();
    dm_read  = 1'b0;
    dm_write = 1'b0;
    repeat (LAT + 3) tick();
    checks++;
    if (nCmdWr - wr0 != 1 || nCmdRd - rd0 != 0) begin
      errors++;
      $display("[TB] FAIL write_cmds: got writes=%0d reads=%0d, required writes=1 reads=0",
               nCmdWr - wr0, nCmdRd - rd0);
    end
    checks++;
    if (nDmDone - dd0 != 1) begin
      errors++;
      $display("[TB] FAIL write_done_count: got %0d, required 1", nDmDone - dd0);
    end
    pushExp(1'b1, 1'b0, 12'h020, 32'h0);
    dm_read = 1'b1;
    waitDone(1'b1, 20, at, sh);
    checks++;
    if (dm_rdata !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL write_readback: got %h, required 12345678", dm_rdata);
    end
    tick();
    dm_read = 1'b0;
    tick();
  endtask

  task automatic test_dm_streak();
    int cmdCycles[$];
    logic [6:0] seq;
    int nGrants, dmK, nBad;
    bit d, i2;
    seq = 7'b0;
    nGrants = 0;
    dmK = 0;
    for (int k = 0; k < 4; k++) pushExp(1'b1, 1'b0, 12'(12'h100 + k), 32'h0);
    pushExp(1'b0, 1'b0, 12'h2FF, 32'h0);
    for (int k = 4; k < 6; k++) pushExp(1'b1, 1'b0, 12'(12'h100 + k), 32'h0);
    dm_address = 12'h100;
    dm_read    = 1'b1;
    im_address = 10'h3FF;
    im_req     = 1'b1;
    for (int i = 0; i < 150 && nGrants < 7; i++) begin
      @(negedge clk);
      if (mem_enable === 1'b1) begin
        cmdCycles.push_back(cyc);
        if (cmdCycles.size() == 5) begin
          checks++;
          if (mem_address !== 12'h2FF) begin
            errors++;
            $display("[TB] FAIL wrap_address: got %h, required 2ff", mem_address);
          end
        end
      end
      d  = (dm_done === 1'b1);
      i2 = (im_done === 1'b1);
      if (d || i2) begin
        seq = {seq[5:0], d};
        nGrants++;
        tick();
        if (d) begin
          dmK++;
          if (dmK < 6) dm_address = 12'(12'h100 + dmK);
          else dm_read = 1'b0;
        end
        if (i2) im_req = 1'b0;
      end
    end
    checks++;
    if (nGrants != 7 || seq !== 7'b1111011) begin
      errors++;
      $display("[TB] FAIL streak_order: got %0d grants seq=%b, required 7 grants seq=1111011",
               nGrants, seq);
    end
    nBad = 0;
    for (int k = 1; k < cmdCycles.size(); k++) begin
      if (cmdCycles[k] - cmdCycles[k-1] != LAT + 3) nBad++;
    end
    checks++;
    if (cmdCycles.size() != 7 || nBad != 0) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %0d commands with %0d bad spacings, required 7 spaced %0d",
               cmdCycles.size(), nBad, LAT + 3);
    end
    dm_read = 1'b0;
    im_req  = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    int r, at, sh;
    pushExp(1'b0, 1'b0, 12'hF40, 32'h0);
    im_address = 10'h040;
    im_req     = 1'b1;
    r = cyc;
    tick();
    im_req = 1'b0;
    waitDone(1'b0, 20, at, sh);
    checks++;
    if (at != r + LAT + 2) begin
      errors++;
      $display("[TB] FAIL drop_done: got cycle %0d, required %0d", at, r + LAT + 2);
    end
    checks++;
    if (sh != 0) begin
      errors++;
      $display("[TB] FAIL drop_stall: got %0d stall cycles, required 0", sh);
    end
    checks++;
    if (im_rdata !== pattern(12'hF40)) begin
      errors++;
      $display("[TB] FAIL drop_rdata: got %h, required %h", im_rdata, pattern(12'hF40));
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int r, at, sh, dd0;
    pushExp(1'b1, 1'b0, 12'h030, 32'h0);
    dm_address = 12'h030;
    dm_read    = 1'b1;
    tick();
    tick();
    rst     = 1'b1;
    dm_read = 1'b0;
    expQ.delete();
    dd0 = nDmDone;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_enable, mem_read, mem_write, mem_address, mem_in, im_done, dm_done,
         dm_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_wait_outputs: got en=%b rd=%b wr=%b addr=%h din=%h imd=%b dmd=%b dmr=%h, required all 0",
               mem_enable, mem_read, mem_write, mem_address, mem_in, im_done, dm_done, dm_rdata);
    end
    repeat (LAT + 3) tick();
    checks++;
    if (nDmDone != dd0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got %0d done pulses, required 0", nDmDone - dd0);
    end
    pushExp(1'b1, 1'b0, 12'h031, 32'h0);
    dm_address = 12'h031;
    dm_read    = 1'b1;
    r = cyc;
    waitDone(1'b1, 20, at, sh);
    checks++;
    if (at != r + LAT + 2) begin
      errors++;
      $display("[TB] FAIL reset_recover_latency: got cycle %0d, required %0d", at, r + LAT + 2);
    end
    checks++;
    if (dm_rdata !== pattern(12'h031)) begin
      errors++;
      $display("[TB] FAIL reset_recover_data: got %h, required %h", dm_rdata, pattern(12'h031));
    end
    tick();
    dm_read = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] mem_arbiter bench start");
    test_reset();
    test_if_read();
    test_simultaneous();
    test_write_both();
    test_dm_streak();
    test_drop();
    test_reset_in_wait();
    repeat (2) tick();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
